// File: rtl/sram_rmw_initiator_if.sv
// Request/response handshake plus single-port SRAM bus used by sram_rmw_initiator.
// master = front end and SRAM macro side, slave = the initiator itself.
interface sram_rmw_initiator_if #(
    parameter int unsigned NumWords  = 1024,
    parameter int unsigned DataWidth = 128,
    parameter int unsigned ByteWidth = 8,
    parameter int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
    parameter int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
);
    logic                 req_valid_i;
    logic                 req_ready_o;
    logic                 req_we_i;
    logic [AddrWidth-1:0] req_addr_i;
    logic [DataWidth-1:0] req_wdata_i;
    logic [BeWidth-1:0]   req_be_i;
    logic                 rsp_valid_o;
    logic                 rsp_ready_i;
    logic [DataWidth-1:0] rsp_rdata_o;
    logic                 rsp_err_o;
    logic                 sram_req_o;
    logic                 sram_we_o;
    logic [AddrWidth-1:0] sram_addr_o;
    logic [DataWidth-1:0] sram_wdata_o;
    logic [BeWidth-1:0]   sram_be_o;
    logic [DataWidth-1:0] sram_rdata_i;
    logic                 init_done_o;

    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i, rsp_ready_i, sram_rdata_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        input  sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o, sram_be_o, init_done_o
    );

    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i, rsp_ready_i, sram_rdata_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        output sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o, sram_be_o, init_done_o
    );
endinterface

// File: rtl/sram_rmw_initiator.sv
// Single-port SRAM initiator: one outstanding request, partial byte-enable writes become read-merge-write.
// Optional power-on zero sweep of the whole array when SRAM_RMW_INIT_CLEAR_EN is defined.
module sram_rmw_initiator #(
    parameter int unsigned NumWords  = 1024,
    parameter int unsigned DataWidth = 128,
    parameter int unsigned ByteWidth = 8,
    localparam int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
    localparam int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    sram_rmw_initiator_if.slave bus
);
    typedef enum logic [2:0] {
`ifdef SRAM_RMW_INIT_CLEAR_EN
        INIT,
`endif
        IDLE,
        RD_WAIT,
        RMW_WAIT,
        RSP
    } state_e;

`ifdef SRAM_RMW_INIT_CLEAR_EN
    localparam state_e             ResetState = INIT;
    localparam logic [AddrWidth:0] LastAddr   = (AddrWidth + 1)'(NumWords - 1);
    logic [AddrWidth:0] cnt_q;
`else
    localparam state_e ResetState = IDLE;
`endif

    state_e               state_q;
    logic [AddrWidth-1:0] addr_q;
    logic [DataWidth-1:0] wdata_q;
    logic [BeWidth-1:0]   be_q;
    logic [DataWidth-1:0] rdata_q;
    logic                 err_q;

    logic                 in_range;
    logic                 be_full;
    logic                 be_none;
    logic                 sram_req;
    logic                 sram_we;
    logic [AddrWidth-1:0] sram_addr;
    logic [DataWidth-1:0] sram_wdata;

    function automatic logic [DataWidth-1:0] merge_lanes(input logic [DataWidth-1:0] old_word,
                                                         input logic [DataWidth-1:0] new_word,
                                                         input logic [BeWidth-1:0]   be);
        logic [DataWidth-1:0] res;
        for (int i = 0; i < DataWidth; i++) begin
            res[i] = be[i / ByteWidth] ? new_word[i] : old_word[i];
        end
        return res;
    endfunction

    // Only a non-power-of-two array can see addresses past its end.
    if ((1 << AddrWidth) > NumWords) begin : g_range_check
        assign in_range = {1'b0, bus.req_addr_i} < (AddrWidth + 1)'(NumWords);
    end else begin : g_range_full
        assign in_range = 1'b1;
    end

    assign be_full = &bus.req_be_i;
    assign be_none = ~|bus.req_be_i;

    always_comb begin
        sram_req   = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (rst_ni) begin
            unique case (state_q)
`ifdef SRAM_RMW_INIT_CLEAR_EN
                INIT: begin
                    sram_req  = 1'b1;
                    sram_we   = 1'b1;
                    sram_addr = cnt_q[AddrWidth-1:0];
                end
`endif
                IDLE: begin
                    // Reads and partial writes both start with a read; only full writes write here.
                    if (bus.req_valid_i && in_range && !(bus.req_we_i && be_none)) begin
                        sram_req   = 1'b1;
                        sram_we    = bus.req_we_i && be_full;
                        sram_addr  = bus.req_addr_i;
                        sram_wdata = sram_we ? bus.req_wdata_i : '0;
                    end
                end
                RMW_WAIT: begin
                    sram_req   = 1'b1;
                    sram_we    = 1'b1;
                    sram_addr  = addr_q;
                    sram_wdata = merge_lanes(bus.sram_rdata_i, wdata_q, be_q);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ResetState;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
`ifdef SRAM_RMW_INIT_CLEAR_EN
            cnt_q   <= '0;
`endif
        end else begin
            unique case (state_q)
`ifdef SRAM_RMW_INIT_CLEAR_EN
                INIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LastAddr) state_q <= IDLE;
                end
`endif
                IDLE: begin
                    if (bus.req_valid_i) begin
                        rdata_q <= '0;
                        err_q   <= !in_range;
                        if (!in_range || (bus.req_we_i && (be_none || be_full))) begin
                            state_q <= RSP;
                        end else if (!bus.req_we_i) begin
                            state_q <= RD_WAIT;
                        end else begin
                            addr_q  <= bus.req_addr_i;
                            wdata_q <= bus.req_wdata_i;
                            be_q    <= bus.req_be_i;
                            state_q <= RMW_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    rdata_q <= bus.sram_rdata_i;
                    state_q <= RSP;
                end
                RMW_WAIT: state_q <= RSP;
                RSP: if (bus.rsp_ready_i) state_q <= IDLE;
                default: state_q <= ResetState;
            endcase
        end
    end

    assign bus.req_ready_o  = (state_q == IDLE);
    assign bus.rsp_valid_o  = (state_q == RSP);
    assign bus.rsp_rdata_o  = rdata_q;
    assign bus.rsp_err_o    = err_q;
    assign bus.sram_req_o   = sram_req;
    assign bus.sram_we_o    = sram_we;
    assign bus.sram_addr_o  = sram_addr;
    assign bus.sram_wdata_o = sram_wdata;
    assign bus.sram_be_o    = {BeWidth{sram_req}};
`ifdef SRAM_RMW_INIT_CLEAR_EN
    assign bus.init_done_o  = (state_q != INIT);
`else
    assign bus.init_done_o  = 1'b1;
`endif
endmodule

// File: tb/tb_sram_rmw_initiator.sv
// Directed bench for sram_rmw_initiator: a 1024x128 instance and a 20-word instance with SRAM models.
`timescale 1ns/1ps
module tb_sram_rmw_initiator;
`ifdef SRAM_RMW_INIT_CLEAR_EN
  localparam bit InitOn = 1'b1;
`else
  localparam bit InitOn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int asserts = 0;
  int failures = 0;

  sram_rmw_initiator_if #(.NumWords(1024), .DataWidth(128), .ByteWidth(8)) bus ();
  sram_rmw_initiator #(.NumWords(1024), .DataWidth(128), .ByteWidth(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus));

  sram_rmw_initiator_if #(.NumWords(20), .DataWidth(32), .ByteWidth(8)) bus2 ();
  sram_rmw_initiator #(.NumWords(20), .DataWidth(32), .ByteWidth(8)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus2));

  // SRAM models: one-cycle read latency, byte enables ignored.
  logic [127:0] mem [1024];
  logic [127:0] rd_q;
  logic         pl_en = 1'b0;
  logic [9:0]   pl_addr = '0;
  logic [127:0] pl_data = '0;
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (bus.sram_req_o) begin
      if (bus.sram_we_o) mem[bus.sram_addr_o] <= bus.sram_wdata_o;
      else rd_q <= mem[bus.sram_addr_o];
    end
  end
  assign bus.sram_rdata_i = rd_q;

  logic [31:0] mem2 [32];
  logic [31:0] rd2_q;
  always @(posedge clk) begin
    if (bus2.sram_req_o) begin
      if (bus2.sram_we_o) mem2[bus2.sram_addr_o] <= bus2.sram_wdata_o;
      else rd2_q <= mem2[bus2.sram_addr_o];
    end
  end
  assign bus2.sram_rdata_i = rd2_q;

`ifdef SRAM_RMW_INIT_CLEAR_EN
  logic rst3_n = 1'b0;
  sram_rmw_initiator_if #(.NumWords(16), .DataWidth(32), .ByteWidth(8)) bus3 ();
  sram_rmw_initiator #(.NumWords(16), .DataWidth(32), .ByteWidth(8)) dut3 (
    .clk_i(clk), .rst_ni(rst3_n), .bus(bus3));
  assign bus3.sram_rdata_i = '0;
`endif

  task automatic preload(input logic [9:0] a, input logic [127:0] d);
    @(posedge clk); #1;
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Presents a request and returns at the negedge of the accept cycle N.
  task automatic issue(input logic we, input logic [9:0] a, input logic [127:0] d, input logic [15:0] be);
    @(posedge clk); #1;
    bus.req_valid_i = 1'b1; bus.req_we_i = we; bus.req_addr_i = a; bus.req_wdata_i = d; bus.req_be_i = be;
    @(negedge clk);
  endtask

  // Withdraws and scrambles the request; returns at the negedge of cycle N+1.
  task automatic drop();
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0; bus.req_we_i = 1'b0; bus.req_addr_i = '0; bus.req_wdata_i = '0; bus.req_be_i = '0;
    @(negedge clk);
  endtask

  task automatic handshake();
    bus.rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.req_valid_i = 0; bus.req_we_i = 0; bus.req_addr_i = '0; bus.req_wdata_i = '0; bus.req_be_i = '0; bus.rsp_ready_i = 0;
    bus2.req_valid_i = 0; bus2.req_we_i = 0; bus2.req_addr_i = '0; bus2.req_wdata_i = '0; bus2.req_be_i = '0; bus2.rsp_ready_i = 0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    asserts++; if ({bus.rsp_valid_o, bus.rsp_err_o, bus.sram_req_o, bus.sram_we_o} !== 4'b0000) begin
      failures++; $display("FAIL reset_ctrl: got %b expected 0000", {bus.rsp_valid_o, bus.rsp_err_o, bus.sram_req_o, bus.sram_we_o}); end
    asserts++; if ({bus.rsp_rdata_o, bus.sram_wdata_o, bus.sram_addr_o, bus.sram_be_o} !== '0) begin
      failures++; $display("FAIL reset_data: rdata %h wdata %h addr %h be %h expected all 0", bus.rsp_rdata_o, bus.sram_wdata_o, bus.sram_addr_o, bus.sram_be_o); end
    asserts++; if ({bus.init_done_o, bus.req_ready_o} !== {!InitOn, !InitOn}) begin
      failures++; $display("FAIL reset_init_ready: got %b expected %b", {bus.init_done_o, bus.req_ready_o}, {!InitOn, !InitOn}); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 1200 && !(bus.init_done_o && bus2.init_done_o); i++) @(negedge clk);
    @(negedge clk);
    asserts++; if ({bus.init_done_o, bus.req_ready_o, bus2.req_ready_o} !== 3'b111) begin
      failures++; $display("FAIL post_reset_ready: got %b expected 111", {bus.init_done_o, bus.req_ready_o, bus2.req_ready_o}); end
  endtask

  task automatic test_read();
    preload(10'd5, {16{8'hA5}});
    issue(1'b0, 10'd5, '0, '0);
    asserts++; if ({bus.req_ready_o, bus.sram_req_o, bus.sram_we_o, bus.sram_addr_o, bus.sram_be_o} !== {3'b110, 10'd5, 16'hFFFF}) begin
      failures++; $display("FAIL read_issue: got %h expected %h", {bus.req_ready_o, bus.sram_req_o, bus.sram_we_o, bus.sram_addr_o, bus.sram_be_o}, {3'b110, 10'd5, 16'hFFFF}); end
    drop();
    asserts++; if ({bus.rsp_valid_o, bus.sram_req_o} !== 2'b00) begin
      failures++; $display("FAIL read_n1: valid/req %b expected 00", {bus.rsp_valid_o, bus.sram_req_o}); end
    @(negedge clk);
    asserts++; if ({bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_rdata_o} !== {2'b10, {16{8'hA5}}}) begin
      failures++; $display("FAIL read_rsp: valid/err %b rdata %h expected 10 %h", {bus.rsp_valid_o, bus.rsp_err_o}, bus.rsp_rdata_o, {16{8'hA5}}); end
    handshake();
    asserts++; if ({bus.req_ready_o, bus.rsp_valid_o} !== 2'b10) begin
      failures++; $display("FAIL read_done: ready/valid %b expected 10", {bus.req_ready_o, bus.rsp_valid_o}); end
  endtask

  task automatic test_full_write();
    logic [127:0] d;
    d = 128'h0123456789ABCDEF_FEDCBA9876543210;
    issue(1'b1, 10'd7, d, 16'hFFFF);
    asserts++; if ({bus.sram_req_o, bus.sram_we_o, bus.sram_addr_o, bus.sram_be_o, bus.sram_wdata_o} !== {2'b11, 10'd7, 16'hFFFF, d}) begin
      failures++; $display("FAIL fullwr_issue: got %h expected %h", {bus.sram_req_o, bus.sram_we_o, bus.sram_addr_o, bus.sram_be_o, bus.sram_wdata_o}, {2'b11, 10'd7, 16'hFFFF, d}); end
    drop();
    asserts++; if ({bus.rsp_valid_o, bus.rsp_err_o, bus.sram_req_o, bus.rsp_rdata_o} !== {3'b100, 128'h0}) begin
      failures++; $display("FAIL fullwr_rsp: flags %b rdata %h expected 100 0", {bus.rsp_valid_o, bus.rsp_err_o, bus.sram_req_o}, bus.rsp_rdata_o); end
    handshake();
    issue(1'b0, 10'd7, '0, '0);
    drop();
    @(negedge clk);
    asserts++; if ({bus.rsp_valid_o, bus.rsp_rdata_o} !== {1'b1, d}) begin
      failures++; $display("FAIL fullwr_readback: valid %b rdata %h expected 1 %h", bus.rsp_valid_o, bus.rsp_rdata_o, d); end
    handshake();
  endtask

  task automatic test_partial_write();
    logic [15:0]  be;
    logic [127:0] d;
    logic [127:0] exp;
    preload(10'd3, {16{8'h11}});
    for (int k = 0; k < 2; k++) begin
      be  = (k == 0) ? 16'h0001 : 16'h8000;
      d   = (k == 0) ? {{15{8'hEE}}, 8'hFF} : {8'h5A, {15{8'hEE}}};
      exp = (k == 0) ? {{15{8'h11}}, 8'hFF} : {8'h5A, {14{8'h11}}, 8'hFF};
      issue(1'b1, 10'd3, d, be);
      asserts++; if ({bus.req_ready_o, bus.sram_req_o, bus.sram_we_o, bus.sram_addr_o} !== {3'b110, 10'd3}) begin
        failures++; $display("FAIL rmw_read_%0d: got %h expected %h", k, {bus.req_ready_o, bus.sram_req_o, bus.sram_we_o, bus.sram_addr_o}, {3'b110, 10'd3}); end
      drop();
      asserts++; if ({bus.sram_req_o, bus.sram_we_o, bus.sram_addr_o, bus.sram_be_o, bus.rsp_valid_o} !== {2'b11, 10'd3, 16'hFFFF, 1'b0}) begin
        failures++; $display("FAIL rmw_write_%0d: got %h expected %h", k, {bus.sram_req_o, bus.sram_we_o, bus.sram_addr_o, bus.sram_be_o, bus.rsp_valid_o}, {2'b11, 10'd3, 16'hFFFF, 1'b0}); end
      asserts++; if (bus.sram_wdata_o !== exp) begin
        failures++; $display("FAIL rmw_merge_%0d: wdata %h expected %h", k, bus.sram_wdata_o, exp); end
      @(negedge clk);
      asserts++; if ({bus.rsp_valid_o, bus.rsp_err_o, bus.sram_req_o, bus.rsp_rdata_o} !== {3'b100, 128'h0}) begin
        failures++; $display("FAIL rmw_rsp_%0d: flags %b rdata %h expected 100 0", k, {bus.rsp_valid_o, bus.rsp_err_o, bus.sram_req_o}, bus.rsp_rdata_o); end
      handshake();
    end
    issue(1'b0, 10'd3, '0, '0);
    drop();
    @(negedge clk);
    asserts++; if ({bus.rsp_valid_o, bus.rsp_rdata_o} !== {1'b1, exp}) begin
      failures++; $display("FAIL rmw_readback: valid %b rdata %h expected 1 %h", bus.rsp_valid_o, bus.rsp_rdata_o, exp); end
    handshake();
  endtask

  task automatic test_be_zero();
    preload(10'd11, {16{8'h3C}});
    issue(1'b1, 10'd11, {128{1'b1}}, 16'h0000);
    asserts++; if ({bus.req_ready_o, bus.sram_req_o} !== 2'b10) begin
      failures++; $display("FAIL bezero_issue: ready/req %b expected 10", {bus.req_ready_o, bus.sram_req_o}); end
    drop();
    asserts++; if ({bus.rsp_valid_o, bus.rsp_err_o, bus.sram_req_o, bus.rsp_rdata_o} !== {3'b100, 128'h0}) begin
      failures++; $display("FAIL bezero_rsp: flags %b rdata %h expected 100 0", {bus.rsp_valid_o, bus.rsp_err_o, bus.sram_req_o}, bus.rsp_rdata_o); end
    handshake();
    issue(1'b0, 10'd11, '0, '0);
    drop();
    @(negedge clk);
    asserts++; if (bus.rsp_rdata_o !== {16{8'h3C}}) begin
      failures++; $display("FAIL bezero_readback: rdata %h expected %h", bus.rsp_rdata_o, {16{8'h3C}}); end
    handshake();
  endtask

  task automatic test_backpressure();
    issue(1'b0, 10'd5, '0, '0);
    drop();
    @(negedge clk);
    bus.req_valid_i = 1'b1; bus.req_we_i = 1'b1; bus.req_addr_i = 10'd9; bus.req_wdata_i = '1; bus.req_be_i = 16'hFFFF;
    for (int i = 0; i < 10; i++) begin
      asserts++; if ({bus.rsp_valid_o, bus.req_ready_o, bus.sram_req_o, bus.rsp_err_o, bus.rsp_rdata_o} !== {4'b1000, {16{8'hA5}}}) begin
        failures++; $display("FAIL hold_%0d: flags %b rdata %h expected 1000 %h", i, {bus.rsp_valid_o, bus.req_ready_o, bus.sram_req_o, bus.rsp_err_o}, bus.rsp_rdata_o, {16{8'hA5}}); end
      @(negedge clk);
    end
    bus.req_valid_i = 1'b0;
    handshake();
    asserts++; if ({bus.req_ready_o, bus.rsp_valid_o, bus.sram_req_o} !== 3'b100) begin
      failures++; $display("FAIL hold_release: ready/valid/req %b expected 100", {bus.req_ready_o, bus.rsp_valid_o, bus.sram_req_o}); end
  endtask

  task automatic test_out_of_range();
    logic [4:0] a;
    logic       w;
    logic       e;
    for (int k = 0; k < 3; k++) begin
      a = (k == 0) ? 5'd25 : (k == 1) ? 5'd20 : 5'd19;
      w = (k == 1);
      e = (a >= 5'd20);
      @(posedge clk); #1;
      bus2.req_valid_i = 1'b1; bus2.req_we_i = w; bus2.req_addr_i = a; bus2.req_wdata_i = 32'hCAFEF00D; bus2.req_be_i = 4'hF;
      @(negedge clk);
      asserts++; if ({bus2.req_ready_o, bus2.sram_req_o} !== {1'b1, !e}) begin
        failures++; $display("FAIL oor_issue_%0d: ready/req %b expected %b", k, {bus2.req_ready_o, bus2.sram_req_o}, {1'b1, !e}); end
      @(posedge clk); #1;
      bus2.req_valid_i = 1'b0;
      @(negedge clk);
      if (!e) begin
        asserts++; if (bus2.rsp_valid_o !== 1'b0) begin
          failures++; $display("FAIL oor_early_%0d: rsp_valid %b expected 0", k, bus2.rsp_valid_o); end
        @(negedge clk);
      end
      asserts++; if ({bus2.rsp_valid_o, bus2.rsp_err_o} !== {1'b1, e}) begin
        failures++; $display("FAIL oor_rsp_%0d: valid/err %b expected %b", k, {bus2.rsp_valid_o, bus2.rsp_err_o}, {1'b1, e}); end
      if (e) begin
        asserts++; if (bus2.rsp_rdata_o !== 32'h0) begin
          failures++; $display("FAIL oor_rdata_%0d: rdata %h expected 0", k, bus2.rsp_rdata_o); end
      end
      bus2.rsp_ready_i = 1'b1;
      @(posedge clk); #1;
      bus2.rsp_ready_i = 1'b0;
      @(negedge clk);
      asserts++; if ({bus2.req_ready_o, bus2.rsp_valid_o} !== 2'b10) begin
        failures++; $display("FAIL oor_done_%0d: ready/valid %b expected 10", k, {bus2.req_ready_o, bus2.rsp_valid_o}); end
    end
  endtask

  task automatic test_reset_mid_op();
    logic [127:0] exp;
    exp = InitOn ? 128'h0 : {16{8'h22}};
    preload(10'd9, {16{8'h22}});
    issue(1'b1, 10'd9, {128{1'b1}}, 16'h00F0);
    asserts++; if ({bus.sram_req_o, bus.sram_we_o} !== 2'b10) begin
      failures++; $display("FAIL midrst_read: req/we %b expected 10", {bus.sram_req_o, bus.sram_we_o}); end
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.req_valid_i = 1'b0;
    @(negedge clk);
    asserts++; if ({bus.sram_req_o, bus.rsp_valid_o, bus.req_ready_o} !== {2'b00, !InitOn}) begin
      failures++; $display("FAIL midrst_state: req/valid/ready %b expected %b", {bus.sram_req_o, bus.rsp_valid_o, bus.req_ready_o}, {2'b00, !InitOn}); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 1200 && !(bus.init_done_o && bus2.init_done_o); i++) @(negedge clk);
    issue(1'b0, 10'd9, '0, '0);
    drop();
    @(negedge clk);
    asserts++; if ({bus.rsp_valid_o, bus.rsp_rdata_o} !== {1'b1, exp}) begin
      failures++; $display("FAIL midrst_readback: valid %b rdata %h expected 1 %h", bus.rsp_valid_o, bus.rsp_rdata_o, exp); end
    handshake();
  endtask

`ifdef SRAM_RMW_INIT_CLEAR_EN
  task automatic test_init_clear();
    bus3.req_valid_i = 0; bus3.req_we_i = 0; bus3.req_addr_i = '0; bus3.req_wdata_i = '0; bus3.req_be_i = '0; bus3.rsp_ready_i = 0;
    for (int pass = 0; pass < 2; pass++) begin
      @(posedge clk); #1;
      rst3_n = 1'b0;
      @(negedge clk);
      asserts++; if ({bus3.sram_req_o, bus3.init_done_o, bus3.req_ready_o} !== 3'b000) begin
        failures++; $display("FAIL init_rst_%0d: req/done/ready %b expected 000", pass, {bus3.sram_req_o, bus3.init_done_o, bus3.req_ready_o}); end
      @(posedge clk); #1;
      rst3_n = 1'b1;
      for (int k = 0; k < ((pass == 0) ? 6 : 16); k++) begin
        @(negedge clk);
        asserts++; if ({bus3.sram_req_o, bus3.sram_we_o, bus3.sram_addr_o, bus3.sram_wdata_o, bus3.sram_be_o, bus3.init_done_o, bus3.req_ready_o} !== {2'b11, 4'(k), 32'h0, 4'hF, 2'b00}) begin
          failures++; $display("FAIL init_sweep_%0d_%0d: got %h expected %h", pass, k, {bus3.sram_req_o, bus3.sram_we_o, bus3.sram_addr_o, bus3.sram_wdata_o, bus3.sram_be_o, bus3.init_done_o, bus3.req_ready_o}, {2'b11, 4'(k), 32'h0, 4'hF, 2'b00}); end
      end
    end
    @(negedge clk);
    asserts++; if ({bus3.init_done_o, bus3.req_ready_o, bus3.sram_req_o} !== 3'b110) begin
      failures++; $display("FAIL init_done: done/ready/req %b expected 110", {bus3.init_done_o, bus3.req_ready_o, bus3.sram_req_o}); end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before the test sequence completed");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_read();
    test_full_write();
    test_partial_write();
    test_be_zero();
    test_backpressure();
    test_out_of_range();
    test_reset_mid_op();
`ifdef SRAM_RMW_INIT_CLEAR_EN
    test_init_clear();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end
endmodule
